key_event_sequencer: RTL and testbench



---
 rtl/key_event_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_key_event_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_sequencer.sv
// -----------------------------------------------------------------------------
// key_event_sequencer
//
// Sits between the PS/2 scan-code translator and the keyboard matrix
// emulator. Make/break events are accepted over a valid/ready handshake and
// buffered in a small FIFO. Keys are then presented to the matrix one at a
// time. Each key is held for at least HOLD_CYCLES, released, and followed by
// a forced idle gap of GAP_CYCLES. This keeps the MC-10 ROM keyboard scan from
// missing a keypress or merging two keys.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   ev_valid  in   event present on ev_code/ev_break
//   ev_ready  out  sequencer can accept an event (FIFO not full)
//   ev_code   in   [7:0] matrix key code {ctrl, column[2:0], shift, row[2:0]}
//   ev_break  in   1 = key release, 0 = key press
//   key_code  out  [7:0] to matrix emulator; 8'hFF = no key
//   key_held  out  1 while a non-idle code is driven
//   busy      out  1 when not IDLE or FIFO non-empty
// -----------------------------------------------------------------------------
module key_event_sequencer #(
   parameter logic [15:0] HOLD_CYCLES = 16'd50000,
   parameter logic [15:0] GAP_CYCLES  = 16'd25000,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [7:0] ev_code,
   input  logic       ev_break,
   output logic [7:0] key_code,
   output logic       key_held,
   output logic       busy
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [7:0] IDLE_KEY = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_GAP
   } state_t;

   // ---------------------------------------------------------------------------
   // Event FIFO. The pointers carry one extra wrap bit, so full and empty can
   // be told apart without a separate occupancy counter.
   // ---------------------------------------------------------------------------
   logic [8:0]  fifo_mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic [8:0]  head;
   logic        head_break;
   logic [7:0]  head_code;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // ev_ready depends only on registered pointers. A full FIFO therefore
   // refuses a push even on an edge where it also pops.
   assign ev_ready   = !fifo_full;
   assign push       = ev_valid && !fifo_full;

   assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];
   assign head_break = head[8];
   assign head_code  = head[7:0];

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= {ev_break, ev_code};
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer state
   // ---------------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  key_code_q, key_code_d;
   logic        key_held_q, key_held_d;
   logic        do_release;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      key_code_d = key_code_q;
      key_held_d = key_held_q;
      pop        = 1'b0;
      do_release = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               // A break at the head with no key held is a stray release.
               // It is popped and dropped.
               pop = 1'b1;
               if (!head_break) begin
                  key_code_d = head_code;
                  key_held_d = 1'b1;
                  cnt_d      = HOLD_CYCLES - 16'd1;
                  state_d    = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!fifo_empty) begin
               // Release point. The FIFO is examined one entry per cycle until
               // the key is let go. With the FIFO empty the key stays held.
               if (head_code == key_code_q) begin
                  // A matching break releases the key. A matching make is a
                  // typematic repeat and is dropped.
                  pop        = 1'b1;
                  do_release = head_break;
               end else if (head_break) begin
                  // A break for some other key is dropped.
                  pop = 1'b1;
               end else begin
                  // A make for a different key releases this one. The new
                  // key stays queued and is pressed later from IDLE.
                  do_release = 1'b1;
               end
            end
         end

         S_GAP: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (do_release) begin
         key_code_d = IDLE_KEY;
         key_held_d = 1'b0;
         cnt_d      = GAP_CYCLES - 16'd1;
         state_d    = S_GAP;
      end
   end

   assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
   assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

   // NOTE: state is updated with non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         key_code_q <= IDLE_KEY;
         key_held_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         key_code_q <= key_code_d;
         key_held_q <= key_held_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   assign key_code = key_code_q;
   assign key_held = key_held_q;
   assign busy     = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_key_event_sequencer.sv
// -----------------------------------------------------------------------------
// tb_key_event_sequencer
//
// Directed bench for key_event_sequencer with HOLD_CYCLES=4, GAP_CYCLES=2 and
// FIFO_DEPTH=4.
//
// The stimulus pushes the expected key_code transitions (new value, plus the
// edge number where the change must land, 0 = any edge) into a queue. A
// monitor runs on the falling edge and pops one entry for every change it
// sees on key_code. Edge numbers count rising clk edges; an event accepted at
// edge E reaches key_code at edge E+1.
// -----------------------------------------------------------------------------
module tb_key_event_sequencer;

   localparam logic [15:0] HOLD  = 16'd4;
   localparam logic [15:0] GAP   = 16'd2;
   localparam int          DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_break;
   logic [7:0] key_code;
   logic       key_held;
   logic       busy;

   key_event_sequencer #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_code  (ev_code),
      .ev_break (ev_break),
      .key_code (key_code),
      .key_held (key_held),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] code;
      int         at;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic       mon_en = 1'b0;
   logic [7:0] prev_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: checks key_held against key_code every cycle and checks every
   // key_code change against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         check("held_vs_code", {31'd0, key_held}, {31'd0, key_code != 8'hFF});
         if (key_code !== prev_code) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_change: key_code became %h at cycle %0d, nothing expected",
                        key_code, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("key_code_seq", {24'd0, key_code}, {24'd0, mon_e.code});
               if (mon_e.at != 0) check("key_code_edge", cyc, mon_e.at);
            end
            prev_code = key_code;
         end
      end
   end

   task automatic expect_key(input logic [7:0] code, input int at);
      exp_q.push_back('{code, at});
   endtask

   // Offers one event and returns the edge that accepted it. ev_valid stays
   // high, so back-to-back calls stream events without gaps.
   task automatic push(input logic [7:0] code, input logic brk, output int acc);
      ev_valid = 1'b1;
      ev_code  = code;
      ev_break = brk;
      acc      = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ev_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: event %h/%0d never accepted", code, brk);
      end
   endtask

   task automatic stop_push();
      ev_valid = 1'b0;
      ev_break = 1'b0;
      ev_code  = 8'h00;
   endtask

   // Returns the edge after which busy was first seen low.
   task automatic wait_idle(output int at);
      at = -1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!busy) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: busy never fell");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] code;
      logic       brk;
   } ev_t;

   ev_t bp_ev[6];
   int  e0, e1, t, acc;

   initial begin
      reset    = 1'b1;
      ev_valid = 1'b0;
      ev_code  = 8'h00;
      ev_break = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Power-on reset state.
      @(negedge clk);
      check("por_key_code", {24'd0, key_code}, 32'hFF);
      check("por_key_held", {31'd0, key_held}, 32'd0);
      check("por_busy",     {31'd0, busy},     32'd0);
      check("por_ev_ready", {31'd0, ev_ready}, 32'd1);
      prev_code = 8'hFF;
      mon_en    = 1'b1;
      @(posedge clk);
      #1;

      // Single key: make at E, break at E+1. The key is held edges E+1..E+5
      // (4 cycles), the gap lasts edges E+5..E+7, and IDLE with an empty
      // FIFO is reached at E+7.
      push(8'h23, 1'b0, e0);
      expect_key(8'h23, e0 + 1);
      push(8'h23, 1'b1, e1);
      stop_push();
      check("single_break_back_to_back", e1, e0 + 1);
      expect_key(8'hFF, e0 + 5);
      wait_idle(t);
      check("single_busy_fall", t, e0 + 7);

      // Reset mid-HOLD with a break already queued. Afterwards the key is
      // re-pressed and must stay held, which shows the old break was dropped.
      push(8'h23, 1'b0, e0);
      expect_key(8'h23, e0 + 1);
      push(8'h23, 1'b1, e1);
      stop_push();
      expect_key(8'hFF, e1 + 1);
      pulse_reset();
      @(negedge clk);
      check("rst_key_code", {24'd0, key_code}, 32'hFF);
      check("rst_key_held", {31'd0, key_held}, 32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_ev_ready", {31'd0, ev_ready}, 32'd1);
      @(posedge clk);
      #1;
      push(8'h23, 1'b0, e0);
      stop_push();
      expect_key(8'h23, e0 + 1);
      repeat (10) @(posedge clk);
      #1;
      check("rst_break_dropped", {24'd0, key_code}, 32'h23);
      check("rst_still_busy",    {31'd0, busy},     32'd1);
      expect_key(8'hFF, cyc + 1);
      pulse_reset();
      @(posedge clk);
      #1;

      // Late break: with no break queued the key is held indefinitely. A
      // break accepted at B releases the key at B+1, and IDLE follows at B+3.
      push(8'h15, 1'b0, e0);
      stop_push();
      expect_key(8'h15, e0 + 1);
      repeat (20) @(posedge clk);
      #1;
      check("late_still_held", {24'd0, key_code}, 32'h15);
      check("late_key_held",   {31'd0, key_held}, 32'd1);
      push(8'h15, 1'b1, e1);
      stop_push();
      expect_key(8'hFF, e1 + 1);
      wait_idle(t);
      check("late_idle", t, e1 + 3);

      // Typematic plus a stray break. The release point starts after edge
      // E+4. It drops make 40 at E+5, make 40 at E+6 and break 07 at E+7,
      // then releases on break 40 at E+8. There is only one press.
      push(8'h40, 1'b0, e0);
      expect_key(8'h40, e0 + 1);
      push(8'h40, 1'b0, acc);
      push(8'h40, 1'b0, acc);
      push(8'h07, 1'b1, acc);
      push(8'h40, 1'b1, acc);
      stop_push();
      check("typematic_no_stall", acc, e0 + 4);
      expect_key(8'hFF, e0 + 8);
      wait_idle(t);
      check("typematic_idle", t, e0 + 10);

      // Rollover. Key 11 is released at E+5 by the queued make 22. 22 is
      // pressed at E+8 after the gap and one IDLE cycle. Break 11 is dropped
      // at E+12, and break 22 releases the key at E+13.
      push(8'h11, 1'b0, e0);
      expect_key(8'h11, e0 + 1);
      push(8'h22, 1'b0, acc);
      push(8'h11, 1'b1, acc);
      push(8'h22, 1'b1, acc);
      stop_push();
      expect_key(8'hFF, e0 + 5);
      expect_key(8'h22, e0 + 8);
      expect_key(8'hFF, e0 + 13);
      wait_idle(t);
      check("rollover_idle",  t, e0 + 15);
      check("rollover_final", {24'd0, key_code}, 32'hFF);

      // Backpressure. Key 30 is held with no break queued, and six events
      // are streamed with ev_valid held high. The FIFO fills on the fourth
      // push. Every key must still come out once and in order.
      bp_ev[0] = '{8'h31, 1'b0};
      bp_ev[1] = '{8'h31, 1'b1};
      bp_ev[2] = '{8'h32, 1'b0};
      bp_ev[3] = '{8'h32, 1'b1};
      bp_ev[4] = '{8'h33, 1'b0};
      bp_ev[5] = '{8'h33, 1'b1};
      push(8'h30, 1'b0, e0);
      stop_push();
      expect_key(8'h30, e0 + 1);
      expect_key(8'hFF, 0);
      expect_key(8'h31, 0);
      expect_key(8'hFF, 0);
      expect_key(8'h32, 0);
      expect_key(8'hFF, 0);
      expect_key(8'h33, 0);
      expect_key(8'hFF, 0);
      for (int i = 0; i < 6; i++) begin
         push(bp_ev[i].code, bp_ev[i].brk, acc);
         if (i == 3) check("bp_ready_low_when_full", {31'd0, ev_ready}, 32'd0);
      end
      stop_push();
      wait_idle(t);
      check("bp_final_key", {24'd0, key_code}, 32'hFF);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
